rp_trig_align: RTL and testbench
================================

RP_TRIG_ALIGN -- requirements
Module: rp_trig_align

Interface
REQ-001 SHALL have parameter DW, default 14, the ADC sample width per channel.
REQ-002 SHALL have parameter CH, default 2, the channel count; all channels share one delay.
REQ-003 SHALL have parameter DLY_W, default 3, the delay select width; maximum delay is DLY_MAX = 2^DLY_W-1.
REQ-004 SHALL have port adc_clk_i, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-005 SHALL have port adc_rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port dly_dat_i, input, CH*DW bits: samples; channel n is at [n*DW +: DW].
REQ-007 SHALL have port dly_val_i, input, 1 bit: sample valid.
REQ-008 SHALL have port set_trg_src_i, input, 4 bits: trigger source code.
REQ-009 SHALL have port set_trg_new_i, input, 1 bit: strobe that latches set_trg_src_i.
REQ-010 SHALL have port tbl_we_i, input, 1 bit: delay-table write strobe.
REQ-011 SHALL have port tbl_adr_i, input, 4 bits: delay-table address (source code).
REQ-012 SHALL have port tbl_dat_i, input, DLY_W+1 bits: table entry; MSB is the hold flag, LSBs are the delay.
REQ-013 SHALL have port dly_dat_o, output, CH*DW bits: delayed samples.
REQ-014 SHALL have port dly_val_o, output, 1 bit: delayed valid, blanked while settling.
REQ-015 SHALL have port cur_dly_o, output, DLY_W bits: active delay.
REQ-016 SHALL have port settle_o, output, 1 bit: high while the FSM is in SETTLE.

Function
REQ-017 SHALL keep, per channel, a DLY_MAX+1 stage data shift line and one shared valid shift line.
REQ-018 Both lines SHALL shift every cycle regardless of dly_val_i.
REQ-019 Stage 0 SHALL register the input directly.
REQ-020 dly_dat_o SHALL register stage[cur_dly], giving an input-to-output latency of cur_dly+2 cycles.
REQ-021 dly_val_o SHALL register valid stage[cur_dly] ANDed with the inverse of SETTLE.
REQ-022 last_src SHALL load set_trg_src_i on the edge where set_trg_new_i=1; otherwise it SHALL hold.
REQ-023 A 16-entry table SHALL supply the target delay combinationally from table[last_src].
REQ-024 The table SHALL reset to the default image: sources 2-5 and 10-13 -> delay 1; sources 6-9 -> delay 2; sources 0, 1, 14 and 15 -> hold.
REQ-025 FSM states SHALL be RUN and SETTLE.
REQ-026 A delay update SHALL occur when the table entry for last_src is not hold and its delay differs from cur_dly.
REQ-027 On a delay update, the FSM SHALL, on the next edge, load cur_dly with the target, load the settle counter with target+2, and enter SETTLE.
REQ-028 In SETTLE, the settle counter SHALL decrement each cycle, and the FSM SHALL return to RUN on the edge where the counter reaches 0.
REQ-029 A delay update during SETTLE SHALL reload cur_dly and the counter and remain in SETTLE.
REQ-030 A hold entry, or an entry equal to cur_dly, SHALL leave cur_dly, the state and the counter unchanged.
REQ-031 Timing SHALL be: set_trg_new_i at edge N -> last_src at N+1 -> cur_dly/SETTLE at N+2 -> first output on the new tap at N+3.
REQ-032 A table write and set_trg_new_i in the same cycle SHALL both take effect at the next edge; the target then uses the new entry.
REQ-033 A table write to the address equal to last_src SHALL trigger an update under the normal rules.
REQ-034 Delay arithmetic SHALL be unsigned; a table delay field SHALL never exceed DLY_MAX by construction.

Reset
REQ-035 adc_rst_i=1 SHALL force, at the next edge: dly_val_o=0, dly_dat_o=0, cur_dly_o=0, settle_o=0, state RUN, counter 0, last_src 0, valid line all 0, and table = default image.
REQ-036 Data shift line contents SHALL NOT be reset.
REQ-037 Reset asserted mid-SETTLE SHALL abort the settle and return to RUN with no blanking carry-over.

Configuration
REQ-038 With macro RP_TRIG_ALIGN_TBL_WR_EN defined, tbl_we_i/tbl_adr_i/tbl_dat_i SHALL write table[tbl_adr_i] <= tbl_dat_i on the edge where tbl_we_i=1.
REQ-039 Without RP_TRIG_ALIGN_TBL_WR_EN, the table SHALL be the constant default image, the table ports SHALL remain present but be ignored, and no table storage SHALL be inferred.

Verification
REQ-040 Reset, then src=6 strobe, ramp input -> cur_dly_o=2 at N+2; settle_o high for 4 cycles; dly_dat_o = input delayed 4 cycles.
REQ-041 Switch src 6 -> 2 -> cur_dly_o=1; settle_o high 3 cycles; dly_val_o=0 during settle; latency 3 afterwards.
REQ-042 Strobe src=0 (hold) after src=7 -> cur_dly_o stays 2; settle_o stays 0; no gap in dly_val_o.
REQ-043 (RP_TRIG_ALIGN_TBL_WR_EN) Write table[3]=0x7 while last_src=3 -> cur_dly_o=7, settle 9 cycles, latency 9; without the macro the same write leaves cur_dly_o=1.
REQ-044 Strobe src=6 and then src=2 one cycle later -> single SETTLE reloaded to 3; final cur_dly_o=1.
REQ-045 Assert adc_rst_i for 1 cycle mid-SETTLE -> next edge: all outputs 0, state RUN, table default.

Source files
------------

// File: rtl/rp_trig_align.sv
// Trigger-source-dependent sample delay line with settle blanking.
// Define RP_TRIG_ALIGN_TBL_WR_EN to make the delay table writable at run time.
module rp_trig_align #(
    parameter int unsigned DW    = 14,
    parameter int unsigned CH    = 2,
    parameter int unsigned DLY_W = 3
) (
    input  logic                adc_clk_i,
    input  logic                adc_rst_i,
    input  logic [CH*DW-1:0]    dly_dat_i,
    input  logic                dly_val_i,
    input  logic [3:0]          set_trg_src_i,
    input  logic                set_trg_new_i,
    input  logic                tbl_we_i,
    input  logic [3:0]          tbl_adr_i,
    input  logic [DLY_W:0]      tbl_dat_i,
    output logic [CH*DW-1:0]    dly_dat_o,
    output logic                dly_val_o,
    output logic [DLY_W-1:0]    cur_dly_o,
    output logic                settle_o
);

    localparam int unsigned DLY_MAX = (1 << DLY_W) - 1;
    localparam int unsigned CW      = DLY_W + 1;

    typedef enum logic {RUN, SETTLE} state_t;

    state_t           state, state_nxt;
    logic [DLY_W-1:0] cur_dly, cur_dly_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [3:0]       last_src;
    logic [DLY_W:0]   entry;
    logic             tgt_hold;
    logic [DLY_W-1:0] tgt_dly;
    logic             upd;

    logic [DW-1:0]    dat_line [CH][DLY_MAX+1];
    logic [DLY_MAX:0] val_line;

    // Default image: MSB set means "hold the current delay".
    function automatic logic [DLY_W:0] def_entry(input logic [3:0] src);
        logic [DLY_W:0] e;
        case (src)
            4'd2, 4'd3, 4'd4, 4'd5,
            4'd10, 4'd11, 4'd12, 4'd13: e = {1'b0, DLY_W'(1)};
            4'd6, 4'd7, 4'd8, 4'd9:     e = {1'b0, DLY_W'(2)};
            default:                    e = {1'b1, {DLY_W{1'b0}}};
        endcase
        return e;
    endfunction

`ifdef RP_TRIG_ALIGN_TBL_WR_EN
    logic [DLY_W:0] tbl [16];

    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            for (int unsigned i = 0; i < 16; i++) begin
                tbl[i] <= def_entry(4'(i));
            end
        end else if (tbl_we_i) begin
            tbl[tbl_adr_i] <= tbl_dat_i;
        end
    end

    assign entry = tbl[last_src];
`else
    logic unused_tbl;
    assign unused_tbl = ^{tbl_we_i, tbl_adr_i, tbl_dat_i};
    assign entry      = def_entry(last_src);
`endif

    // Data line carries no reset; only the valid line is cleared.
    always_ff @(posedge adc_clk_i) begin
        for (int unsigned c = 0; c < CH; c++) begin
            dat_line[c][0] <= dly_dat_i[c*DW +: DW];
            for (int unsigned s = 1; s <= DLY_MAX; s++) begin
                dat_line[c][s] <= dat_line[c][s-1];
            end
        end
    end

    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            val_line <= '0;
        end else begin
            val_line <= {val_line[DLY_MAX-1:0], dly_val_i};
        end
    end

    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            last_src <= '0;
        end else if (set_trg_new_i) begin
            last_src <= set_trg_src_i;
        end
    end

    assign tgt_hold = entry[DLY_W];
    assign tgt_dly  = entry[DLY_W-1:0];
    assign upd      = !tgt_hold && (tgt_dly != cur_dly);

    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            state   <= RUN;
            cur_dly <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_nxt;
            cur_dly <= cur_dly_nxt;
            cnt     <= cnt_nxt;
        end
    end

    // An update wins over the countdown, so a new target mid-settle restarts it.
    always_comb begin
        state_nxt   = state;
        cur_dly_nxt = cur_dly;
        cnt_nxt     = cnt;
        if (upd) begin
            state_nxt   = SETTLE;
            cur_dly_nxt = tgt_dly;
            cnt_nxt     = CW'(tgt_dly) + CW'(2);
        end else if (state == SETTLE) begin
            cnt_nxt = cnt - CW'(1);
            if (cnt == CW'(1)) begin
                state_nxt = RUN;
            end
        end
    end

    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            dly_dat_o <= '0;
            dly_val_o <= 1'b0;
        end else begin
            for (int unsigned c = 0; c < CH; c++) begin
                dly_dat_o[c*DW +: DW] <= dat_line[c][cur_dly];
            end
            dly_val_o <= val_line[cur_dly] && (state != SETTLE);
        end
    end

    assign cur_dly_o = cur_dly;
    assign settle_o  = (state == SETTLE);

endmodule

// File: tb/tb_rp_trig_align.sv
// Self-checking bench for rp_trig_align: directed scenarios then random traffic
// against a cycle-indexed history model.
module tb_rp_trig_align;

    localparam int DW    = 14;
    localparam int CH    = 2;
    localparam int DLY_W = 3;
    localparam int W     = CH * DW;
    localparam int HMAX  = 8192;

    logic             clk = 1'b0;
    logic             adc_rst_i = 1'b1;
    logic [W-1:0]     dly_dat_i = '0;
    logic             dly_val_i = 1'b0;
    logic [3:0]       set_trg_src_i = '0;
    logic             set_trg_new_i = 1'b0;
    logic             tbl_we_i = 1'b0;
    logic [3:0]       tbl_adr_i = '0;
    logic [DLY_W:0]   tbl_dat_i = '0;
    logic [W-1:0]     dly_dat_o;
    logic             dly_val_o;
    logic [DLY_W-1:0] cur_dly_o;
    logic             settle_o;

    rp_trig_align #(.DW(DW), .CH(CH), .DLY_W(DLY_W)) dut (
        .adc_clk_i     (clk),
        .adc_rst_i     (adc_rst_i),
        .dly_dat_i     (dly_dat_i),
        .dly_val_i     (dly_val_i),
        .set_trg_src_i (set_trg_src_i),
        .set_trg_new_i (set_trg_new_i),
        .tbl_we_i      (tbl_we_i),
        .tbl_adr_i     (tbl_adr_i),
        .tbl_dat_i     (tbl_dat_i),
        .dly_dat_o     (dly_dat_o),
        .dly_val_o     (dly_val_o),
        .cur_dly_o     (cur_dly_o),
        .settle_o      (settle_o)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Model: input history per cycle, delay per source (-1 = hold),
    // and the first cycle index that is no longer blanked.
    logic [W-1:0] dh [HMAX];
    bit           vh [HMAX];
    int           m_tbl [16];
    int           m_src = 0;
    int           m_dly = 0;
    int           settle_until = 0;
    int           cutoff = 0;
    int           cyc = 0;
    bit           have_exp = 0;
    bit           exp_val = 0;
    logic [W-1:0] exp_dat = '0;

    function automatic int def_dly(input int s);
        if ((s >= 2 && s <= 5) || (s >= 10 && s <= 13)) return 1;
        if (s >= 6 && s <= 9) return 2;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        int idx;
        int e;
        bit was_rst;
        bit settle_old;
        was_rst = adc_rst_i;
        if (cyc < HMAX) begin
            dh[cyc] = dly_dat_i;
            vh[cyc] = dly_val_i;
        end
        @(posedge clk);
        if (was_rst) begin
            exp_val = 0;
            exp_dat = '0;
            m_dly = 0;
            m_src = 0;
            settle_until = 0;
            cutoff = cyc;
            for (int i = 0; i < 16; i++) m_tbl[i] = def_dly(i);
            have_exp = 1;
        end else begin
            idx = cyc - 1 - m_dly;
            settle_old = (cyc < settle_until);
            exp_val = (idx > cutoff) && (idx < HMAX) && vh[idx] && !settle_old;
            if (exp_val) exp_dat = dh[idx];
            e = m_tbl[m_src];
            if (e >= 0 && e != m_dly) begin
                m_dly = e;
                settle_until = cyc + 1 + e + 2;
            end
            if (set_trg_new_i) m_src = int'(set_trg_src_i);
`ifdef RP_TRIG_ALIGN_TBL_WR_EN
            if (tbl_we_i) m_tbl[tbl_adr_i] = tbl_dat_i[DLY_W] ? -1 : int'(tbl_dat_i[DLY_W-1:0]);
`endif
        end
        cyc++;
        #1;
        if (have_exp) begin
            chk("cur_dly", 64'(cur_dly_o), 64'(m_dly));
            chk("settle", 64'(settle_o), 64'(cyc < settle_until));
            chk("dly_val", 64'(dly_val_o), 64'(exp_val));
            if (was_rst || exp_val) chk("dly_dat", 64'(dly_dat_o), 64'(exp_dat));
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            dly_dat_i = {DW'(cyc + 500), DW'(cyc)};
            dly_val_i = 1'b1;
            tick();
        end
    endtask

    task automatic strobe(input int src);
        set_trg_src_i = 4'(src);
        set_trg_new_i = 1'b1;
        dly_dat_i = {DW'(cyc + 500), DW'(cyc)};
        dly_val_i = 1'b1;
        tick();
        set_trg_new_i = 1'b0;
    endtask

    initial begin
        // Reset
        adc_rst_i = 1'b1;
        repeat (3) tick();
        chk("rst_cur_dly", 64'(cur_dly_o), 64'd0);
        chk("rst_settle", 64'(settle_o), 64'd0);
        chk("rst_val", 64'(dly_val_o), 64'd0);
        adc_rst_i = 1'b0;
        run(6);

        // src 6: delay 2, settle 4 cycles
        strobe(6);
        run(1);
        chk("req40_dly", 64'(cur_dly_o), 64'd2);
        chk("req40_settle", 64'(settle_o), 64'd1);
        run(10);

        // src 2: delay 1, settle 3 cycles
        strobe(2);
        run(12);
        chk("req41_dly", 64'(cur_dly_o), 64'd1);

        // src 7 then hold source 0
        strobe(7);
        run(10);
        strobe(0);
        run(10);
        chk("req42_dly", 64'(cur_dly_o), 64'd2);
        chk("req42_settle", 64'(settle_o), 64'd0);

        // Table write to the active source
        strobe(3);
        run(8);
        tbl_we_i  = 1'b1;
        tbl_adr_i = 4'd3;
        tbl_dat_i = 4'h7;
        tick();
        tbl_we_i  = 1'b0;
        run(14);
`ifdef RP_TRIG_ALIGN_TBL_WR_EN
        chk("req43_dly", 64'(cur_dly_o), 64'd7);
`else
        chk("req43_dly", 64'(cur_dly_o), 64'd1);
`endif

        // Back-to-back strobes: single reloaded settle
        strobe(6);
        strobe(2);
        run(10);
        chk("req44_dly", 64'(cur_dly_o), 64'd1);

        // Reset in the middle of a settle
        strobe(8);
        run(3);
        adc_rst_i = 1'b1;
        tick();
        adc_rst_i = 1'b0;
        chk("req45_dly", 64'(cur_dly_o), 64'd0);
        chk("req45_settle", 64'(settle_o), 64'd0);
        chk("req45_dat", 64'(dly_dat_o), 64'd0);
        run(6);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            dly_dat_i     = W'({$urandom(), $urandom()});
            dly_val_i     = ($urandom_range(0, 3) != 0);
            set_trg_new_i = ($urandom_range(0, 7) == 0);
            set_trg_src_i = 4'($urandom_range(0, 15));
            tbl_we_i      = ($urandom_range(0, 15) == 0);
            tbl_adr_i     = 4'($urandom_range(0, 15));
            tbl_dat_i     = (DLY_W+1)'($urandom_range(0, 15));
            adc_rst_i     = ($urandom_range(0, 199) == 0);
            tick();
        end
        adc_rst_i     = 1'b0;
        set_trg_new_i = 1'b0;
        tbl_we_i      = 1'b0;
        run(12);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
